// File: rtl/ws_pkg.sv
// Shared types and helpers for the weight-stationary activation feeder.
package ws_pkg;

  localparam int D_W_DEF  = 8;
  localparam int ROWS_DEF = 4;
  // Widest vector the slice helper handles (ROWS*D_W must not exceed this).
  localparam int VEC_MAX  = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } ws_state_e;

  // Element idx of width w from a flat vector, zero-extended to VEC_MAX.
  function automatic logic [VEC_MAX-1:0] vec_slice(input logic [VEC_MAX-1:0] v,
                                                   input int unsigned idx,
                                                   input int unsigned w);
    logic [VEC_MAX-1:0] mask;
    mask = (VEC_MAX'(1) << w) - VEC_MAX'(1);
    return (v >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/ws_vec_fifo.sv
// Synchronous vector FIFO; flags come from the registered count only.
module ws_vec_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ws_act_skew_feeder.sv
// Buffers activation vectors and issues them diagonally skewed into the
// left edge of the WS PE array: row r lags row 0 by r cycles.
module ws_act_skew_feeder
  import ws_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROWS*D_W-1:0] in_vec,
  input  logic                in_last,
  input  logic                weight_busy,
  output logic [ROWS*D_W-1:0] out_act,
  output logic [ROWS-1:0]     out_act_valid,
  output logic                busy,
  output logic                frame_done
);
  localparam int VW = ROWS * D_W;
  localparam int CW = $clog2(ROWS + 1);

  logic          full, empty, push, pop, pop_last;
  logic [VW-1:0] pop_vec;
  ws_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !weight_busy && (state_q != ST_DRAIN);

  ws_vec_fifo #(.W(VW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_last, in_vec}),
    .rdata_o ({pop_last, pop_vec}),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DRAIN lasts ROWS cycles so its final cycle matches the last row's output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (pop) begin
        state_d = pop_last ? ST_DRAIN : ST_STREAM;
        if (pop_last) cnt_d = CW'(ROWS);
      end
      ST_STREAM: if (pop && pop_last) begin
        state_d = ST_DRAIN;
        cnt_d   = CW'(ROWS);
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DRAIN) && (cnt_q == CW'(1));
  end

  // Per-row delay line: r stage registers plus the output register, free-running.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][D_W-1:0] dat_q;
    logic [r:0]          vld_pipe;
    logic [D_W-1:0]      elem;

    assign elem = D_W'(vec_slice(VEC_MAX'(pop_vec), r, D_W));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q    <= '0;
        vld_pipe <= '0;
      end else begin
        dat_q[0]    <= pop ? elem : '0;
        vld_pipe[0] <= pop;
        for (int k = r; k > 0; k--) begin
          dat_q[k]    <= dat_q[k-1];
          vld_pipe[k] <= vld_pipe[k-1];
        end
      end
    end

    assign out_act[r*D_W +: D_W] = dat_q[r];
    assign out_act_valid[r]      = vld_pipe[r];
  end

endmodule

// File: tb/tb_ws_act_skew_feeder.sv
// Directed bench for ws_act_skew_feeder with a queue-based reference model.
module tb_ws_act_skew_feeder;
  localparam int D_W = 8, ROWS = 4, DEPTH = 4, VW = ROWS * D_W;

  logic            clk, rst_n, in_valid, in_ready, in_last, weight_busy, busy, frame_done;
  logic [VW-1:0]   in_vec, out_act;
  logic [ROWS-1:0] out_act_valid;

  ws_act_skew_feeder #(.D_W(D_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_last(in_last), .weight_busy(weight_busy),
    .out_act(out_act), .out_act_valid(out_act_valid), .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  // Reference model: pending vectors, which cycle popped what, frame bookkeeping.
  logic [VW:0]   mq[$];
  bit            pv [0:4095];
  logic [VW-1:0] pd [0:4095];
  int            last_cyc  = -100;
  int            rst_floor = 0;
  bit            frame_on  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model step at the edge closing cycle cyc: pop unless empty, stalled or draining.
  initial begin
    bit m_drn, m_pop, m_push;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        last_cyc  = -100;
        frame_on  = 0;
        pv[cyc]   = 0;
        rst_floor = cyc + 1;
      end else begin
        m_drn  = (cyc >= last_cyc + 1) && (cyc <= last_cyc + ROWS);
        m_push = in_valid && (mq.size() < DEPTH);
        m_pop  = (mq.size() > 0) && !weight_busy && !m_drn;
        if (cyc == last_cyc + ROWS) frame_on = 0;
        pv[cyc] = m_pop;
        if (m_pop) begin
          pd[cyc]  = mq[0][VW-1:0];
          if (mq[0][VW]) last_cyc = cyc;
          frame_on = 1;
          void'(mq.pop_front());
        end
        if (m_push) mq.push_back({in_last, in_vec});
      end
      cyc++;
    end
  end

  // Row r in cycle m shows whatever was popped in cycle m-1-r.
  initial begin
    logic [VW-1:0]   ea;
    logic [ROWS-1:0] ev;
    int              k;
    forever begin
      @(negedge clk);
      ea = '0;
      ev = '0;
      if (!rst_n) begin
        chk("rst_act", out_act, 0);
        chk("rst_vld", out_act_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_ready", in_ready, 0);
      end else begin
        for (int r = 0; r < ROWS; r++) begin
          k = cyc - 1 - r;
          if (k >= 0 && k >= rst_floor && pv[k]) begin
            ev[r] = 1'b1;
            ea[r*D_W +: D_W] = pd[k][r*D_W +: D_W];
          end
        end
        chk("out_act", out_act, ea);
        chk("out_vld", out_act_valid, ev);
        chk("busy", busy, frame_on);
        chk("frame_done", frame_done, (cyc == last_cyc + ROWS));
        chk("in_ready", in_ready, (mq.size() < DEPTH));
      end
    end
  end

  function automatic logic [VW-1:0] vv(input int i);
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*D_W +: D_W] = D_W'(16 * i + r + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int n);
    if (cyc > n) begin
      fails++;
      $display("FAIL wait_neg: at cycle %0d required %0d", cyc, n);
    end
    while (cyc < n) step();
    @(negedge clk);
  endtask

  task automatic push(input logic [VW-1:0] v, input logic last);
    int n = 0;
    in_valid = 1'b1; in_vec = v; in_last = last;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n >= 50) begin
      fails++;
      $display("FAIL push_timeout: in_ready %0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || mq.size() != 0) && n < 200) begin step(); n++; end
    if (n >= 200) begin
      fails++;
      $display("FAIL idle_timeout: busy %0b required 0", busy);
    end
    step();
  endtask

  int c0, p;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; weight_busy = 1'b0; in_vec = '0;
    @(negedge clk);
    chk("t0_ready_in_reset", in_ready, 0);
    step(); step();
    rst_n = 1'b1;
    #1 chk("t0_ready_after", in_ready, 1);
    step();

    // Single last vector {4,3,2,1}
    c0 = cyc;
    in_valid = 1'b1; in_last = 1'b1; in_vec = 32'h04030201;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      wait_neg(c0 + 2 + r);
      chk("t1_row_val", out_act[r*D_W +: D_W], r + 1);
      chk("t1_row_vld", out_act_valid[r], 1);
      chk("t1_busy", busy, 1);
      chk("t1_fdone", frame_done, (r == ROWS - 1));
    end
    wait_neg(c0 + 6);
    chk("t1_busy_end", busy, 0);
    step();

    // Fill while weights load; fifth vector held until a pop frees space
    weight_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(vv(i), 1'b0);
    chk("t2_full_ready", in_ready, 0);
    in_valid = 1'b1; in_vec = vv(4); in_last = 1'b1;
    step(); step();
    weight_busy = 1'b0;
    p = cyc;
    chk("t2_hold", in_ready, 0);
    step();
    chk("t2_accept", in_ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_idle();

    // Three vectors with a two-cycle weight stall between the first two
    c0 = cyc;
    in_valid = 1'b1; in_vec = vv(8);
    step();
    in_vec = vv(9);
    step();
    in_vec = vv(10); in_last = 1'b1; weight_busy = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    weight_busy = 1'b0;
    wait_neg(c0 + 9);
    chk("t3_fdone", frame_done, 1);
    chk("t3_row3", out_act[3*D_W +: D_W], 8'd164);
    step();
    wait_idle();

    // Push into empty FIFO while draining
    c0 = cyc;
    in_valid = 1'b1; in_last = 1'b1; in_vec = vv(11);
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_vec = vv(12);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_neg(c0 + 5);
    chk("t4_fdone1", frame_done, 1);
    wait_neg(c0 + 6);
    chk("t4_no_early", out_act_valid[0], 0);
    wait_neg(c0 + 7);
    chk("t4_row0", out_act[D_W-1:0], 8'd193);
    chk("t4_vld0", out_act_valid[0], 1);
    wait_neg(c0 + 10);
    chk("t4_fdone2", frame_done, 1);
    step();
    wait_idle();

    // Async reset mid-drain with two vectors buffered
    c0 = cyc;
    in_valid = 1'b1; in_last = 1'b1; in_vec = vv(13);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    push(vv(14), 1'b0);
    push(vv(15), 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("t5_act_now", out_act, 0);
    chk("t5_busy_now", busy, 0);
    wait_neg(c0 + 5);
    chk("t5_no_fdone", frame_done, 0);
    step();
    rst_n = 1'b1;
    #1 chk("t5_ready", in_ready, 1);
    step(); step(); step();
    chk("t5_empty", out_act_valid, 0);
    wait_idle();

    // Pointer wrap with alternating gaps and stalls
    for (int i = 0; i < 10; i++) begin
      push(vv(20 + i), (i == 9));
      if (i % 2 == 1) begin
        weight_busy = 1'b1;
        step();
        weight_busy = 1'b0;
      end else step();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws_act_skew_feeder.md
Name: ws_act_skew_feeder

Overview:
- Sits directly upstream of the left column of the weight-stationary PE array and drives each row's in_act.
- Accepts one activation vector per handshake (one element per array row) and buffers vectors in a small FIFO.
- Issues buffered vectors with a diagonal skew: row r sees element r exactly r cycles after row 0. This gives the time alignment the WS array needs for partial sums flowing down the columns.
- Inserts zero bubbles when idle, holds issue while weights are loading, and drains and flags end of frame.

Parameters:
- D_W, 8, activation element width (matches PE D_W)
- ROWS, 4, number of array rows = elements per vector
- DEPTH, 4, input FIFO depth in vectors (power of 2, >=2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  upstream vector valid
- in_ready  out  1  FIFO can accept a vector
- in_vec  in  ROWS*D_W  activation vector; element r at [r*D_W +: D_W]
- in_last  in  1  marks final vector of a frame
- weight_busy  in  1  array is loading weights (drives PE weight_we); blocks issue
- out_act  out  ROWS*D_W  per-row activation to PE in_act; row r at [r*D_W +: D_W]
- out_act_valid  out  ROWS  per-row valid qualifier (debug/fault monitor)
- busy  out  1  frame in progress (STREAM or DRAIN)
- frame_done  out  1  one-cycle pulse when last skewed element of a frame has left row ROWS-1

Behaviour:
- Reset (rst_n low, async):
  - FIFO pointers and count cleared; state IDLE.
  - All skew registers, out_act, out_act_valid, busy and frame_done cleared to 0.
  - in_ready is 0 while reset is asserted, then 1 (FIFO empty).
  - Reset mid-frame discards all buffered and in-flight data with no frame_done.
- FIFO:
  - push = in_valid && in_ready; stores {in_last, in_vec}.
  - in_ready = !full, derived from registered count only; no combinational dependence on pop.
  - A full FIFO with a same-cycle pop still refuses the push.
  - No bypass: a vector pushed into an empty FIFO is eligible for pop the next cycle.
  - Pointers wrap mod DEPTH. Simultaneous push and pop leaves count unchanged.
- Issue (pop) condition: !empty && !weight_busy && state != DRAIN.
- Skew pipeline:
  - It shifts every cycle unconditionally, since the PE has no stall.
  - On pop at edge t: row 0 out_act = element 0 at t+1; row r out_act = element r at t+1+r; matching out_act_valid[r] = 1.
  - A cycle with no pop injects zeros with valid 0 into the head of every row chain.
  - Row r uses r stage registers plus one output register.
  - Back-to-back pops produce one vector per cycle per row.
- FSM:
  - IDLE: pop -> STREAM. If the popped vector has last=1 -> DRAIN directly.
  - STREAM: a pop with last=1 -> DRAIN. weight_busy only stalls issue; state is unchanged.
  - DRAIN: a counter loads ROWS on entry and decrements each cycle. At 0, frame_done = 1 for one cycle -> IDLE. The pulse coincides with the cycle in which out_act_valid[ROWS-1] of the last vector is high.
  - busy = (state != IDLE).
- weight_busy rising in STREAM stalls further pops; already-issued vectors continue to skew out. There is no stall in DRAIN.
- Widths: data is pass-through only with no arithmetic; the counter is clog2(ROWS+1) bits.

Decomposition:
- Shared package ws_pkg: D_W and ROWS defaults, FSM state encoding (IDLE/STREAM/DRAIN), and a vector-slice helper function.
- One natural sub-module: ws_vec_fifo, a parameterised sync FIFO of width ROWS*D_W+1 and depth DEPTH with full/empty/count.
- The skew chain is a generate loop inside the top.

Test Plan (ROWS=4, D_W=8, DEPTH=4):
- Single vector {4,3,2,1} (elem0=1) with last=1, pushed at cycle 0:
  - Pop at cycle 1.
  - Row0=1 @2, row1=2 @3, row2=3 @4, row3=4 @5.
  - frame_done pulses @5; busy is 1 over cycles 2-5, then 0.
- Five back-to-back vectors with in_valid held high and no pops (weight_busy=1):
  - in_ready drops after the 4th accept; the 5th is held.
  - On weight_busy=0, one pop per cycle; the 5th vector is accepted the cycle after the first pop.
- Stream of 3 vectors (last on the 3rd) with weight_busy=1 for 2 cycles between vectors 1 and 2:
  - Each row shows exactly 2 zero, valid=0 gaps, in correct skew.
  - frame_done arrives 4 cycles after the 3rd pop.
- Push into an empty FIFO while a frame is draining:
  - The new vector is not popped until the cycle after frame_done.
  - It then follows the normal skew.
- rst_n asserted asynchronously mid-DRAIN with 2 vectors buffered:
  - All outputs are 0 immediately; no frame_done.
  - After release, in_ready=1 and the FIFO is empty.
- Pointer wrap:
  - 10 vectors through with alternating push/pop gaps.
  - Output order and values match input order on all rows.
